// File: rtl/keypad_scanner.sv
// Keypad scanner for the alarm clock front end.
// Drives the three columns of a 4x3 matrix keypad low one at a time and samples
// the active-low rows at the end of each column slot. After each full scan the
// 12-bit result is decoded and debounced. The committed key is then presented
// as a digit code with a one-cycle valid pulse. '*' and '#' are decoded to the
// alarm and time buttons.
module keypad_scanner #(
    parameter int SCAN_DIV       = 4,
    parameter int DEBOUNCE_SCANS = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row_in,
    output logic [2:0] col_out,
    output logic [3:0] key,
    output logic       key_valid,
    output logic       time_button,
    output logic       alarm_button
);

    localparam int SLOT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DEB_W  = $clog2(DEBOUNCE_SCANS + 1);

    localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0]  DEB_TARGET = DEB_W'(DEBOUNCE_SCANS);

    localparam logic [3:0] NOKEY     = 4'hA;
    localparam logic [3:0] CODE_STAR = 4'hB;
    localparam logic [3:0] CODE_HASH = 4'hC;

    typedef enum logic [1:0] {
        COL0 = 2'd0,
        COL1 = 2'd1,
        COL2 = 2'd2
    } col_state_e;

    // Internal code for the key at (row, col). Rows 0-2 hold digits 1-9;
    // row 3 holds '*', '0' and '#'.
    function automatic logic [3:0] code_of(input int r, input int c);
        logic [3:0] code;
        if (r < 3) begin
            code = 4'(r * 3 + c + 1);
        end else if (c == 0) begin
            code = CODE_STAR;
        end else if (c == 1) begin
            code = 4'd0;
        end else begin
            code = CODE_HASH;
        end
        return code;
    endfunction

    col_state_e        state_q, state_d;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [11:0]       scan_q;
    logic [11:0]       scan_full;
    logic              slot_end;
    logic              scan_end;
    logic [3:0]        result;

    logic [3:0]        prev_q, prev_d;
    logic [DEB_W-1:0]  deb_q, deb_d;
    logic [3:0]        committed_q, committed_d;
    logic              commit_q, commit_d;

    logic [3:0]        key_q;
    logic              key_valid_q;
    logic              time_q;
    logic              alarm_q;

    assign slot_end = (slot_q == SLOT_LAST);
    assign scan_end = slot_end && (state_q == COL2);

    // Column FSM state and slot counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= COL0;
            slot_q  <= '0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
        end
    end

    // Advance the slot counter, step to the next column on the slot's last cycle,
    // and drive only the active column low.
    always_comb begin
        state_d = state_q;
        slot_d  = slot_q + SLOT_W'(1);
        col_out = 3'b111;
        case (state_q)
            COL0:    col_out = 3'b110;
            COL1:    col_out = 3'b101;
            COL2:    col_out = 3'b011;
            default: col_out = 3'b111;
        endcase
        if (slot_end) begin
            slot_d = '0;
            case (state_q)
                COL0:    state_d = COL1;
                COL1:    state_d = COL2;
                default: state_d = COL0;
            endcase
        end
    end

    // Scan vector with the active column's slice replaced by the current row
    // sample. It is only used on the last cycle of a slot.
    always_comb begin
        scan_full = scan_q;
        case (state_q)
            COL0:    scan_full[3:0]  = ~row_in;
            COL1:    scan_full[7:4]  = ~row_in;
            default: scan_full[11:8] = ~row_in;
        endcase
    end

    // Latch the column's row sample at the end of each slot.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scan_q <= '0;
        end else if (slot_end) begin
            scan_q <= scan_full;
        end
    end

    // Decode a full scan. Exactly one closed switch gives that key's code.
    // No switch, or several switches (multi-press or ghosting), gives NOKEY.
    always_comb begin
        result = NOKEY;
        if ((scan_full != 12'd0) && ((scan_full & (scan_full - 12'd1)) == 12'd0)) begin
            for (int c = 0; c < 3; c++) begin
                for (int r = 0; r < 4; r++) begin
                    if (scan_full[c*4 + r]) begin
                        result = code_of(r, c);
                    end
                end
            end
        end
    end

    // Debounce. Count consecutive identical scan results and commit once the
    // run is long enough and the result differs from the committed key.
    always_comb begin
        prev_d      = prev_q;
        deb_d       = deb_q;
        committed_d = committed_q;
        commit_d    = 1'b0;
        if (scan_end) begin
            if (result == prev_q) begin
                if (deb_q != DEB_TARGET) begin
                    deb_d = deb_q + DEB_W'(1);
                end
            end else begin
                deb_d  = DEB_W'(1);
                prev_d = result;
            end
            if ((deb_d == DEB_TARGET) && (result != committed_q)) begin
                committed_d = result;
                commit_d    = 1'b1;
            end
        end
    end

    // Debounce state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_q      <= NOKEY;
            deb_q       <= '0;
            committed_q <= NOKEY;
            commit_q    <= 1'b0;
        end else begin
            prev_q      <= prev_d;
            deb_q       <= deb_d;
            committed_q <= committed_d;
            commit_q    <= commit_d;
        end
    end

    // Present the committed key one cycle after it commits. A valid pulse is
    // produced only when the new committed key is a digit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            key_q       <= NOKEY;
            key_valid_q <= 1'b0;
            time_q      <= 1'b0;
            alarm_q     <= 1'b0;
        end else begin
            key_q       <= (committed_q <= 4'd9) ? committed_q : NOKEY;
            key_valid_q <= commit_q && (committed_q <= 4'd9);
            time_q      <= (committed_q == CODE_HASH);
            alarm_q     <= (committed_q == CODE_STAR);
        end
    end

    assign key          = key_q;
    assign key_valid    = key_valid_q;
    assign time_button  = time_q;
    assign alarm_button = alarm_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Testbench for keypad_scanner. A behavioural keypad model pulls rows low for
// pressed keys in the driven column. Expected output events are queued when a
// key pattern is applied, and compared against events seen at the DUT outputs.
`timescale 1ns/1ps
module tb_keypad_scanner;

    typedef struct packed {
        logic [3:0] key;
        logic       tb;
        logic       ab;
        logic       kv;
        int         cyc;
    } ev_t;

    // Key masks: bit index = col*4 + row
    localparam logic [11:0] K1   = 12'h001;
    localparam logic [11:0] K2   = 12'h010;
    localparam logic [11:0] K3   = 12'h100;
    localparam logic [11:0] K5   = 12'h020;
    localparam logic [11:0] K9   = 12'h400;
    localparam logic [11:0] STAR = 12'h008;
    localparam logic [11:0] HASH = 12'h800;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  row_in, row_in2;
    logic [2:0]  col_out, col_out2;
    logic [3:0]  key, key2;
    logic        key_valid, key_valid2;
    logic        time_button, time_button2;
    logic        alarm_button, alarm_button2;

    logic [11:0] pressed    = '0;
    logic [11:0] pressed2   = '0;
    logic        force_en   = 1'b0;
    logic [3:0]  force_rows = 4'hF;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int pulses = 0;

    ev_t exp_q[$];
    ev_t act_q[$];
    logic [5:0] last_out = {4'hA, 2'b00};

    keypad_scanner dut (
        .clk          (clk),
        .reset        (reset_n),
        .row_in       (row_in),
        .col_out      (col_out),
        .key          (key),
        .key_valid    (key_valid),
        .time_button  (time_button),
        .alarm_button (alarm_button)
    );

    keypad_scanner #(.SCAN_DIV(2), .DEBOUNCE_SCANS(1)) dut_fast (
        .clk          (clk),
        .reset        (reset_n),
        .row_in       (row_in2),
        .col_out      (col_out2),
        .key          (key2),
        .key_valid    (key_valid2),
        .time_button  (time_button2),
        .alarm_button (alarm_button2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Keypad model: a pressed key pulls its row low while its column is driven low.
    always_comb begin
        row_in  = 4'hF;
        row_in2 = 4'hF;
        for (int c = 0; c < 3; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (pressed[c*4 + r] && !col_out[c])   row_in[r]  = 1'b0;
                if (pressed2[c*4 + r] && !col_out2[c]) row_in2[r] = 1'b0;
            end
        end
        if (force_en) row_in = force_rows;
    end

    // Output monitor: any output change or valid pulse becomes an event.
    always @(negedge clk) begin
        ev_t ev;
        if (key_valid) pulses++;
        if (reset_n && (({key, time_button, alarm_button} != last_out) || key_valid)) begin
            ev = '{key, time_button, alarm_button, key_valid, cyc};
            act_q.push_back(ev);
        end
        last_out = {key, time_button, alarm_button};
    end

    // Wait for the negedge just after a column-0 slot begins (scan boundary).
    task automatic align(input bit fast);
        logic [2:0] prev;
        logic [2:0] cur;
        prev = fast ? col_out2 : col_out;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            cur = fast ? col_out2 : col_out;
            if (cur == 3'b110 && prev == 3'b011) return;
            prev = cur;
        end
        checks++;
        errors++;
        $display("FAIL align scan boundary not seen, col_out=%b required 110 after 011", cur);
    endtask

    task automatic test_reset();
        int c0;
        int n;
        ev_t e;
        ev_t a;
        force_en   = 1'b1;
        force_rows = 4'b1110;
        reset_n    = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({col_out, key, key_valid, time_button, alarm_button} !== {3'b110, 4'hA, 3'b000}) begin
            errors++;
            $display("FAIL reset_init col=%b key=%h kv=%b tb=%b ab=%b required 110 a 0 0 0",
                     col_out, key, key_valid, time_button, alarm_button);
        end
        force_en = 1'b0;
        pressed  = K5;
        reset_n  = 1'b1;
        repeat (18) @(negedge clk);
        checks++;
        if (col_out !== 3'b101) begin
            errors++;
            $display("FAIL reset_midscan col_out=%b required 101", col_out);
        end
        #2;
        reset_n    = 1'b0;
        force_en   = 1'b1;
        force_rows = 4'b1110;
        #1;
        checks++;
        if ({col_out, key, key_valid, time_button, alarm_button} !== {3'b110, 4'hA, 3'b000}) begin
            errors++;
            $display("FAIL reset_async col=%b key=%h kv=%b tb=%b ab=%b required 110 a 0 0 0",
                     col_out, key, key_valid, time_button, alarm_button);
        end
        repeat (4) @(negedge clk);
        checks++;
        if ({col_out, key, key_valid, time_button, alarm_button} !== {3'b110, 4'hA, 3'b000}) begin
            errors++;
            $display("FAIL reset_held col=%b key=%h kv=%b tb=%b ab=%b required 110 a 0 0 0",
                     col_out, key, key_valid, time_button, alarm_button);
        end
        force_en = 1'b0;
        reset_n  = 1'b1;
        c0 = cyc;
        e = '{4'd5, 1'b0, 1'b0, 1'b1, c0 + 37};
        exp_q.push_back(e);
        align(1'b0);
        align(1'b0);
        align(1'b0);
        c0 = cyc;
        pressed = '0;
        e = '{4'hA, 1'b0, 1'b0, 1'b0, c0 + 37};
        exp_q.push_back(e);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n = 0;
            while (act_q.size() == 0 && n < 800) begin @(negedge clk); n++; end
            checks++;
            if (act_q.size() == 0) begin
                errors++;
                $display("FAIL reset_event timeout, required key=%h kv=%b at cyc %0d", e.key, e.kv, e.cyc);
            end else begin
                a = act_q.pop_front();
                if (a !== e) begin
                    errors++;
                    $display("FAIL reset_event got key=%h tb=%b ab=%b kv=%b cyc=%0d required key=%h tb=%b ab=%b kv=%b cyc=%0d",
                             a.key, a.tb, a.ab, a.kv, a.cyc, e.key, e.tb, e.ab, e.kv, e.cyc);
                end
            end
        end
    endtask

    task automatic test_hold5();
        int c0;
        int n;
        int p0;
        ev_t e;
        ev_t a;
        align(1'b0);
        c0 = cyc;
        pressed = K5;
        e = '{4'd5, 1'b0, 1'b0, 1'b1, c0 + 37};
        exp_q.push_back(e);
        p0 = pulses;
        repeat (240) @(negedge clk);
        checks++;
        if (pulses - p0 !== 1) begin
            errors++;
            $display("FAIL hold5_pulses got %0d pulses over 20 scans required 1", pulses - p0);
        end
        checks++;
        if (key !== 4'd5) begin
            errors++;
            $display("FAIL hold5_key got %h required 5", key);
        end
        align(1'b0);
        c0 = cyc;
        pressed = '0;
        e = '{4'hA, 1'b0, 1'b0, 1'b0, c0 + 37};
        exp_q.push_back(e);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n = 0;
            while (act_q.size() == 0 && n < 800) begin @(negedge clk); n++; end
            checks++;
            if (act_q.size() == 0) begin
                errors++;
                $display("FAIL hold5_event timeout, required key=%h kv=%b at cyc %0d", e.key, e.kv, e.cyc);
            end else begin
                a = act_q.pop_front();
                if (a !== e) begin
                    errors++;
                    $display("FAIL hold5_event got key=%h tb=%b ab=%b kv=%b cyc=%0d required key=%h tb=%b ab=%b kv=%b cyc=%0d",
                             a.key, a.tb, a.ab, a.kv, a.cyc, e.key, e.tb, e.ab, e.kv, e.cyc);
                end
            end
        end
    endtask

    task automatic test_bounce();
        int c0;
        int n;
        ev_t e;
        ev_t a;
        align(1'b0);
        c0 = cyc;
        pressed = K5;
        repeat (12) @(negedge clk);
        pressed = '0;
        repeat (12) @(negedge clk);
        pressed = K5;
        e = '{4'd5, 1'b0, 1'b0, 1'b1, c0 + 61};
        exp_q.push_back(e);
        repeat (60) @(negedge clk);
        align(1'b0);
        c0 = cyc;
        pressed = '0;
        e = '{4'hA, 1'b0, 1'b0, 1'b0, c0 + 37};
        exp_q.push_back(e);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n = 0;
            while (act_q.size() == 0 && n < 800) begin @(negedge clk); n++; end
            checks++;
            if (act_q.size() == 0) begin
                errors++;
                $display("FAIL bounce_event timeout, required key=%h kv=%b at cyc %0d", e.key, e.kv, e.cyc);
            end else begin
                a = act_q.pop_front();
                if (a !== e) begin
                    errors++;
                    $display("FAIL bounce_event got key=%h tb=%b ab=%b kv=%b cyc=%0d required key=%h tb=%b ab=%b kv=%b cyc=%0d",
                             a.key, a.tb, a.ab, a.kv, a.cyc, e.key, e.tb, e.ab, e.kv, e.cyc);
                end
            end
        end
    endtask

    task automatic test_multi();
        int c0;
        int n;
        ev_t e;
        ev_t a;
        align(1'b0);
        pressed = K1 | K2;
        repeat (72) @(negedge clk);
        checks++;
        if (act_q.size() !== 0 || key !== 4'hA) begin
            errors++;
            $display("FAIL multi_press got %0d events key=%h required 0 events key=a", act_q.size(), key);
        end
        align(1'b0);
        c0 = cyc;
        pressed = K1;
        e = '{4'd1, 1'b0, 1'b0, 1'b1, c0 + 37};
        exp_q.push_back(e);
        repeat (48) @(negedge clk);
        align(1'b0);
        c0 = cyc;
        pressed = '0;
        e = '{4'hA, 1'b0, 1'b0, 1'b0, c0 + 37};
        exp_q.push_back(e);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n = 0;
            while (act_q.size() == 0 && n < 800) begin @(negedge clk); n++; end
            checks++;
            if (act_q.size() == 0) begin
                errors++;
                $display("FAIL multi_event timeout, required key=%h kv=%b at cyc %0d", e.key, e.kv, e.cyc);
            end else begin
                a = act_q.pop_front();
                if (a !== e) begin
                    errors++;
                    $display("FAIL multi_event got key=%h tb=%b ab=%b kv=%b cyc=%0d required key=%h tb=%b ab=%b kv=%b cyc=%0d",
                             a.key, a.tb, a.ab, a.kv, a.cyc, e.key, e.tb, e.ab, e.kv, e.cyc);
                end
            end
        end
    endtask

    task automatic test_buttons();
        int c0;
        int n;
        int p0;
        ev_t e;
        ev_t a;
        p0 = pulses;
        align(1'b0);
        c0 = cyc;
        pressed = HASH;
        e = '{4'hA, 1'b1, 1'b0, 1'b0, c0 + 37};
        exp_q.push_back(e);
        repeat (48) @(negedge clk);
        align(1'b0);
        c0 = cyc;
        pressed = STAR;
        e = '{4'hA, 1'b0, 1'b1, 1'b0, c0 + 37};
        exp_q.push_back(e);
        repeat (48) @(negedge clk);
        align(1'b0);
        c0 = cyc;
        pressed = '0;
        e = '{4'hA, 1'b0, 1'b0, 1'b0, c0 + 37};
        exp_q.push_back(e);
        repeat (48) @(negedge clk);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n = 0;
            while (act_q.size() == 0 && n < 800) begin @(negedge clk); n++; end
            checks++;
            if (act_q.size() == 0) begin
                errors++;
                $display("FAIL buttons_event timeout, required tb=%b ab=%b at cyc %0d", e.tb, e.ab, e.cyc);
            end else begin
                a = act_q.pop_front();
                if (a !== e) begin
                    errors++;
                    $display("FAIL buttons_event got key=%h tb=%b ab=%b kv=%b cyc=%0d required key=%h tb=%b ab=%b kv=%b cyc=%0d",
                             a.key, a.tb, a.ab, a.kv, a.cyc, e.key, e.tb, e.ab, e.kv, e.cyc);
                end
            end
        end
        checks++;
        if (pulses - p0 !== 0) begin
            errors++;
            $display("FAIL buttons_pulses got %0d key_valid pulses required 0", pulses - p0);
        end
    endtask

    task automatic test_slide();
        int c0;
        int n;
        int p0;
        ev_t e;
        ev_t a;
        p0 = pulses;
        align(1'b0);
        c0 = cyc;
        pressed = K3;
        e = '{4'd3, 1'b0, 1'b0, 1'b1, c0 + 37};
        exp_q.push_back(e);
        repeat (48) @(negedge clk);
        align(1'b0);
        c0 = cyc;
        pressed = K9;
        e = '{4'd9, 1'b0, 1'b0, 1'b1, c0 + 37};
        exp_q.push_back(e);
        repeat (48) @(negedge clk);
        align(1'b0);
        c0 = cyc;
        pressed = '0;
        e = '{4'hA, 1'b0, 1'b0, 1'b0, c0 + 37};
        exp_q.push_back(e);
        repeat (48) @(negedge clk);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n = 0;
            while (act_q.size() == 0 && n < 800) begin @(negedge clk); n++; end
            checks++;
            if (act_q.size() == 0) begin
                errors++;
                $display("FAIL slide_event timeout, required key=%h kv=%b at cyc %0d", e.key, e.kv, e.cyc);
            end else begin
                a = act_q.pop_front();
                if (a !== e) begin
                    errors++;
                    $display("FAIL slide_event got key=%h tb=%b ab=%b kv=%b cyc=%0d required key=%h tb=%b ab=%b kv=%b cyc=%0d",
                             a.key, a.tb, a.ab, a.kv, a.cyc, e.key, e.tb, e.ab, e.kv, e.cyc);
                end
            end
        end
        checks++;
        if (pulses - p0 !== 2 || act_q.size() !== 0) begin
            errors++;
            $display("FAIL slide_pulses got %0d pulses %0d extra events required 2 pulses 0 extra",
                     pulses - p0, act_q.size());
        end
    endtask

    task automatic test_fast();
        logic [3:0] digits [2];
        digits[0] = 4'd3;
        digits[1] = 4'd9;
        for (int i = 0; i < 2; i++) begin
            align(1'b1);
            pressed2 = (i == 0) ? K3 : K9;
            repeat (6) @(posedge clk);
            #1;
            checks++;
            if (key_valid2 !== 1'b0) begin
                errors++;
                $display("FAIL fast_early key_valid=%b at 6 cycles required 0", key_valid2);
            end
            @(posedge clk);
            #1;
            checks++;
            if (key_valid2 !== 1'b1 || key2 !== digits[i] || time_button2 !== 1'b0 || alarm_button2 !== 1'b0) begin
                errors++;
                $display("FAIL fast_latency key_valid=%b key=%h tb=%b ab=%b at 7 cycles required 1 %h 0 0",
                         key_valid2, key2, time_button2, alarm_button2, digits[i]);
            end
            @(posedge clk);
            #1;
            checks++;
            if (key_valid2 !== 1'b0 || key2 !== digits[i]) begin
                errors++;
                $display("FAIL fast_width key_valid=%b key=%h after pulse required 0 %h", key_valid2, key2, digits[i]);
            end
        end
        pressed2 = '0;
    endtask

    initial begin
        reset_n = 1'b0;
        test_reset();
        test_hold5();
        test_bounce();
        test_multi();
        test_buttons();
        test_slide();
        test_fast();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Upstream stage of the alarm clock: scans a 4x3 matrix keypad, debounces it, and produces the 4-bit key code consumed by the controller and the key shift register.
- Also decodes '*' into alarm_button and '#' into time_button, so the top level runs from one physical keypad.
- Purely synchronous to clk; no dependency on one_second timing.

Parameters:
- SCAN_DIV, 4, clk cycles each column is driven low (>=2); rows are sampled on the last cycle of each slot.
- DEBOUNCE_SCANS, 3, consecutive identical full-scan results required before committing (>=1).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- row_in  input  4  keypad rows, active-low (externally pulled up); bit r = row r
- col_out  output  3  column drives, active-low one-hot; bit c = column c
- key  output  4  committed code: 0-9 = digit held; 4'hA = NOKEY
- key_valid  output  1  one-cycle pulse when key commits to a new digit
- time_button  output  1  high while '#' is the committed key
- alarm_button  output  1  high while '*' is the committed key

Behaviour:
- Keypad layout (row,col):
  - row0 = 1 2 3
  - row1 = 4 5 6
  - row2 = 7 8 9
  - row3 = * 0 #
- Reset (reset=0, async) values:
  - col_out=3'b110; key=4'hA; key_valid=0; time_button=0; alarm_button=0.
  - Slot counter=0, column index=0, debounce count=0, previous scan=NOKEY, committed=NOKEY.
  - Reset asserted mid-scan or mid-debounce discards all partial results; scanning restarts at column 0 on the first clk after release.
- Scan FSM, states COL0 -> COL1 -> COL2 -> COL0:
  - Each state lasts SCAN_DIV cycles; col_out drives only the active column low.
  - A full scan takes 3*SCAN_DIV cycles (12 at defaults).
  - On the last cycle of each slot, ~row_in is captured into that column's 4-bit slice of a 12-bit scan vector.
- Scan result is formed at the end of the COL2 slot:
  - Exactly one bit set -> internal code for that position: digits 0-9, '*' = 4'hB, '#' = 4'hC.
  - Zero bits set -> NOKEY.
  - Two or more bits set (multi-press or ghosting) -> NOKEY.
- Debounce:
  - Result equal to previous scan: count increments, saturating at DEBOUNCE_SCANS.
  - Result different: count=1 and previous scan=result.
  - When count reaches DEBOUNCE_SCANS and the result differs from committed, committed=result on that cycle.
- Output update, registered one cycle after commit:
  - key = committed if it is a digit, else 4'hA.
  - alarm_button = (committed==B); time_button = (committed==C).
  - key_valid pulses high for exactly one cycle, concurrent with key, whenever committed changes to a digit. This includes a direct digit-to-digit change without an intervening release.
  - A change to NOKEY, '*' or '#' produces no key_valid.
- Holding a key produces no repeat pulses. Outputs stay stable until a different debounced result commits.
- Latency from a stable press at a scan boundary to the key_valid pulse: DEBOUNCE_SCANS full scans + 1 cycle (37 cycles at defaults). Worst case adds one further scan.
- A bounce that breaks the run of identical results restarts the debounce count. A glitch shorter than one scan that is not sampled has no effect.
- Counter widths are $clog2-derived from the parameters. There are no combinational paths from row_in to any output.

Test Plan:
- Reset low mid-scan with row_in=4'b1110 -> col_out=3'b110, key=4'hA, all pulses/buttons 0; after release the first key_valid occurs only after 3 fresh scans.
- Hold '5' (row1 low when col1 driven), defaults -> key=4'd5 with one key_valid pulse; no further pulses over 20 scans; release -> key=4'hA after 3 scans, no pulse.
- '5' bouncing (released on scan 2 of 3), then stable -> commit only after 3 consecutive '5' scans; exactly one key_valid.
- Press '1' and '2' together -> key stays 4'hA, no key_valid; release '2' leaving '1' -> key=4'd1 with pulse.
- Hold '#' -> time_button=1, key=4'hA, no key_valid; switch to '*' -> time_button=0, alarm_button=1 on the same cycle.
- Slide '3' to '9' without release -> key 4'd3 then 4'd9, two key_valid pulses; repeat with SCAN_DIV=2, DEBOUNCE_SCANS=1 -> latency 7 cycles.
